alu4_sequencer: RTL and testbench

Multi-cycle controller that drives the team's 4-bit combinational ALU (alu4). It accepts 12-bit instructions over a valid/ready handshake and reads operands from an internal 4×4-bit register file. It presents opcode and operands to the ALU, then writes the ALU result and flags back. It sits between the instruction source and alu4. alu4 is instantiated outside this block and connected through the alu_* ports.

---
 rtl/alu4_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu4_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu4_sequencer.sv
// Multi-cycle controller for the external 4-bit ALU: accepts 12-bit instructions,
// reads operands from a 4x4 register file, and writes results and flags back.
module alu4_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [11:0] instr,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [2:0]  alu_opcode,
  input  logic [3:0]  alu_result,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic        flag_c,
  output logic        flag_z,
  output logic        done,
  input  logic [1:0]  rf_raddr,
  output logic [3:0]  rf_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_ready;
  logic        w_done;
  logic        w_accept;
  logic        r_ldi;
  logic [1:0]  r_rd;
  logic [3:0]  r_imm;
  logic [3:0]  r_alu_a;
  logic [3:0]  r_alu_b;
  logic [2:0]  r_alu_opcode;
  logic        r_flag_c;
  logic        r_flag_z;
  logic [3:0]  r_rf [0:3];

  assign w_accept = instr_valid && w_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_ISSUE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ISSUE: w_next_state = S_WB;
      S_WB:    w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake and retire outputs, decoded straight from the state register
  always_comb begin
    w_ready = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE:  w_ready = 1'b1;
      S_ISSUE: w_ready = 1'b0;
      S_WB:    w_done  = 1'b1;
      default: begin
        w_ready = 1'b0;
        w_done  = 1'b0;
      end
    endcase
  end

  // Instruction latch, ALU operand presentation and flag capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ldi        <= 1'b0;
      r_rd         <= 2'd0;
      r_imm        <= 4'd0;
      r_alu_a      <= 4'd0;
      r_alu_b      <= 4'd0;
      r_alu_opcode <= 3'd0;
      r_flag_c     <= 1'b0;
      r_flag_z     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ldi <= instr[11];
        r_rd  <= instr[7:6];
        r_imm <= instr[3:0];
        // LDI leaves the ALU-facing registers untouched
        if (!instr[11]) begin
          r_alu_a      <= r_rf[instr[5:4]];
          r_alu_b      <= r_rf[instr[3:2]];
          r_alu_opcode <= instr[10:8];
        end
      end
      if ((r_state == S_ISSUE) && !r_ldi) begin
        r_flag_c <= alu_carry;
        r_flag_z <= alu_zero;
      end
    end
  end

  // Register file writeback at the end of ISSUE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_rf[i] <= 4'd0;
      end
    end else if (r_state == S_ISSUE) begin
      if (r_ldi) begin
        r_rf[r_rd] <= r_imm;
      end else begin
        r_rf[r_rd] <= alu_result;
      end
    end
  end

  assign instr_ready = w_ready;
  assign done        = w_done;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_opcode  = r_alu_opcode;
  assign flag_c      = r_flag_c;
  assign flag_z      = r_flag_z;
  assign rf_rdata    = r_rf[rf_raddr];

endmodule

// File: tb/tb_alu4_sequencer.sv
// Directed bench for alu4_sequencer with a behavioural alu4 attached to the alu_* ports.
module tb_alu4_sequencer;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [11:0] instr;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [2:0]  alu_opcode;
  logic [3:0]  alu_result;
  logic        alu_carry;
  logic        alu_zero;
  logic        flag_c;
  logic        flag_z;
  logic        done;
  logic [1:0]  rf_raddr;
  logic [3:0]  rf_rdata;

  int checks;
  int failures;

  alu4_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_result  (alu_result),
    .alu_carry   (alu_carry),
    .alu_zero    (alu_zero),
    .flag_c      (flag_c),
    .flag_z      (flag_z),
    .done        (done),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural alu4: carry is carry-out for ADD/INC, borrow for SUB/DEC, 0 otherwise
  logic [4:0] alu_full;
  always_comb begin
    alu_full = 5'd0;
    case (alu_opcode)
      3'd0: alu_full = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: alu_full = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_full = {1'b0, alu_a & alu_b};
      3'd3: alu_full = {1'b0, alu_a | alu_b};
      3'd4: alu_full = {1'b0, alu_a ^ alu_b};
      3'd5: alu_full = {1'b0, ~alu_a};
      3'd6: alu_full = {1'b0, alu_a} + 5'd1;
      3'd7: alu_full = {1'b0, alu_a} - 5'd1;
      default: alu_full = 5'd0;
    endcase
  end
  assign alu_result = alu_full[3:0];
  assign alu_carry  = alu_full[4];
  assign alu_zero   = (alu_full[3:0] == 4'd0);

  localparam logic [11:0] LDI_R1_9  = 12'h849;
  localparam logic [11:0] LDI_R2_8  = 12'h888;
  localparam logic [11:0] ADD_R3    = 12'h0D8;  // r3 = r1 + r2
  localparam logic [11:0] SUB_R0    = 12'h114;  // r0 = r1 - r1
  localparam logic [11:0] DEC_R0    = 12'h700;  // r0 = r0 - 1
  localparam logic [11:0] XOR_R1    = 12'h458;  // r1 = r1 ^ r2
  localparam logic [11:0] LDI_R0_1  = 12'h801;
  localparam logic [11:0] LDI_R1_2  = 12'h842;
  localparam logic [11:0] LDI_R2_3  = 12'h883;
  localparam logic [11:0] LDI_R3_5  = 12'h8C5;

  task automatic read_rf(input logic [1:0] idx, output logic [3:0] val);
    rf_raddr = idx;
    #1;
    val = rf_rdata;
  endtask

  // Issues one instruction; returns done/ready seen on the three negedges after acceptance
  task automatic exec(input logic [11:0] ins, output logic [2:0] done_pat,
                      output logic [2:0] ready_pat, output logic timed_out);
    timed_out = 1'b0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = ins;
    for (int i = 0; i < 10 && !instr_ready; i++) @(negedge clk);
    if (!instr_ready) timed_out = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    done_pat[2] = done; ready_pat[2] = instr_ready;
    @(negedge clk);
    done_pat[1] = done; ready_pat[1] = instr_ready;
    @(negedge clk);
    done_pat[0] = done; ready_pat[0] = instr_ready;
  endtask

  task automatic test_reset;
    logic [3:0] v;
    rst = 1'b1; instr_valid = 1'b0; instr = 12'd0; rf_raddr = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      read_rf(2'(i), v);
      checks++;
      if (v !== 4'd0) begin failures++; $display("FAIL reset_rf%0d got=%0d exp=0", i, v); end
    end
    checks++;
    if ({flag_c, flag_z, done, instr_ready} !== 4'b0001) begin
      failures++; $display("FAIL reset_ctrl got c,z,done,ready=%b exp=0001", {flag_c, flag_z, done, instr_ready});
    end
    checks++;
    if ({alu_a, alu_b, alu_opcode} !== 11'd0) begin
      failures++; $display("FAIL reset_alu_regs got=%h exp=0", {alu_a, alu_b, alu_opcode});
    end
  endtask

  task automatic test_load_add;
    logic [2:0] dp, rp;
    logic to;
    logic [3:0] v;
    logic [11:0] prog [3];
    prog[0] = LDI_R1_9; prog[1] = LDI_R2_8; prog[2] = ADD_R3;
    for (int i = 0; i < 3; i++) begin
      exec(prog[i], dp, rp, to);
      checks++;
      if (to || dp !== 3'b010 || rp !== 3'b001) begin
        failures++; $display("FAIL load_add_timing%0d done=%b ready=%b timeout=%b exp done=010 ready=001", i, dp, rp, to);
      end
    end
    read_rf(2'd3, v);
    checks++;
    if (v !== 4'd1) begin failures++; $display("FAIL add_r3 got=%0d exp=1", v); end
    checks++;
    if ({flag_c, flag_z} !== 2'b10) begin failures++; $display("FAIL add_flags got cz=%b exp=10", {flag_c, flag_z}); end
  endtask

  task automatic test_sub_zero;
    logic [2:0] dp, rp;
    logic to;
    logic [3:0] v;
    exec(SUB_R0, dp, rp, to);
    read_rf(2'd0, v);
    checks++;
    if (to || v !== 4'd0 || {flag_c, flag_z} !== 2'b01) begin
      failures++; $display("FAIL sub_zero r0=%0d cz=%b exp r0=0 cz=01", v, {flag_c, flag_z});
    end
  endtask

  task automatic test_dec_borrow;
    logic [2:0] dp, rp;
    logic to;
    logic [3:0] v;
    exec(DEC_R0, dp, rp, to);
    read_rf(2'd0, v);
    checks++;
    if (to || v !== 4'd15 || {flag_c, flag_z} !== 2'b10) begin
      failures++; $display("FAIL dec_borrow r0=%0d cz=%b exp r0=15 cz=10", v, {flag_c, flag_z});
    end
  endtask

  task automatic test_xor_in_place;
    logic [2:0] dp, rp;
    logic to;
    logic [3:0] v;
    exec(XOR_R1, dp, rp, to);
    read_rf(2'd1, v);
    checks++;
    if (to || v !== 4'd1 || {flag_c, flag_z} !== 2'b00) begin
      failures++; $display("FAIL xor_in_place r1=%0d cz=%b exp r1=1 cz=00", v, {flag_c, flag_z});
    end
    checks++;
    if ({alu_a, alu_b, alu_opcode} !== {4'd9, 4'd8, 3'd4}) begin
      failures++; $display("FAIL xor_operands got a=%0d b=%0d op=%0d exp a=9 b=8 op=4", alu_a, alu_b, alu_opcode);
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] prog [4];
    logic [3:0] v;
    logic [3:0] exp_rf [4];
    int idx;
    int ndone;
    prog[0] = LDI_R0_1; prog[1] = LDI_R1_2; prog[2] = LDI_R2_3; prog[3] = ADD_R3;
    exp_rf[0] = 4'd1; exp_rf[1] = 4'd2; exp_rf[2] = 4'd3; exp_rf[3] = 4'd5;
    idx = 0;
    ndone = 0;
    @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      if (idx < 4) begin instr_valid = 1'b1; instr = prog[idx]; end
      else instr_valid = 1'b0;
      checks++;
      if (instr_ready !== ((c % 3) == 0)) begin
        failures++; $display("FAIL b2b_ready cycle%0d got=%b exp=%b", c, instr_ready, (c % 3) == 0);
      end
      if (done === 1'b1) ndone++;
      if (instr_ready && instr_valid) idx++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    checks++;
    if (idx !== 4 || ndone !== 4) begin
      failures++; $display("FAIL b2b_counts accepted=%0d done=%0d exp 4 and 4", idx, ndone);
    end
    for (int i = 0; i < 4; i++) begin
      read_rf(2'(i), v);
      checks++;
      if (v !== exp_rf[i]) begin failures++; $display("FAIL b2b_rf%0d got=%0d exp=%0d", i, v, exp_rf[i]); end
    end
  endtask

  task automatic test_reset_mid;
    logic [2:0] dp, rp;
    logic to;
    logic [3:0] v;
    int ndone;
    exec(LDI_R1_9, dp, rp, to);
    exec(LDI_R2_8, dp, rp, to);
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = ADD_R3;
    @(negedge clk);
    instr_valid = 1'b0;
    checks++;
    if (instr_ready !== 1'b0 || alu_a !== 4'd9) begin
      failures++; $display("FAIL mid_issue ready=%b a=%0d exp ready=0 a=9", instr_ready, alu_a);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({instr_ready, done, flag_c, flag_z} !== 4'b1000 || {alu_a, alu_b, alu_opcode} !== 11'd0) begin
      failures++; $display("FAIL mid_reset_outputs ready,done,c,z=%b alu=%h exp 1000 and 0",
                           {instr_ready, done, flag_c, flag_z}, {alu_a, alu_b, alu_opcode});
    end
    ndone = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    read_rf(2'd3, v);
    checks++;
    if (v !== 4'd0 || ndone !== 0) begin
      failures++; $display("FAIL mid_reset_abort r3=%0d dones=%0d exp r3=0 dones=0", v, ndone);
    end
    exec(LDI_R3_5, dp, rp, to);
    read_rf(2'd3, v);
    checks++;
    if (to || v !== 4'd5 || dp !== 3'b010) begin
      failures++; $display("FAIL post_reset_ldi r3=%0d done=%b exp r3=5 done=010", v, dp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_load_add();
    test_sub_zero();
    test_dec_borrow();
    test_xor_in_place();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
